// File: rtl/simplebox_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simplebox_pkg
// Purpose  : Shared constants and types for the simpleBox host-side streamer:
//            default image geometry, engine restart index, byte count,
//            controller state encoding, write-port field slices and the
//            packing of the engine's result word.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package simplebox_pkg;

  // Default image geometry and the index value that restarts simpleBox
  localparam int WIDTH     = 100;
  localparam int HEIGHT    = 100;
  localparam int RESET_IDX = 99999;

  // Bytes per RGB image
  localparam int N = WIDTH * HEIGHT * 3;

  // Controller states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST0     = 3'd1,
    RST1     = 3'd2,
    PREFETCH = 3'd3,
    STREAM   = 3'd4,
    DRAIN    = 3'd5,
    READ     = 3'd6,
    CAPTURE  = 3'd7
  } state_t;

  // Field slices of hex_value_index
  localparam int IDX_LSB = 0;
  localparam int IDX_MSB = 23;
  localparam int VAL_LSB = 24;
  localparam int VAL_MSB = 31;
  localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;
  localparam int VAL_W   = VAL_MSB - VAL_LSB + 1;

  // Result word packing {x_min, y_min, x_max, y_max}, MSB first
  localparam int COORD_W  = 8;
  localparam int XMIN_LSB = 24;
  localparam int YMIN_LSB = 16;
  localparam int XMAX_LSB = 8;
  localparam int YMAX_LSB = 0;

endpackage : simplebox_pkg
`default_nettype wire

// File: rtl/simplebox_streamer.sv
`default_nettype none
// ============================================================================
// Module   : simplebox_streamer
// Purpose  : On start, restarts the simpleBox engine, streams one RGB image
//            from a byte-wide sync-read pixel memory into its write port,
//            reads back the packed result and presents the box coordinates.
// Ports    : CLOCK_50        - system clock
//            reset_n         - synchronous active-low reset
//            start           - single-cycle request to process one image
//            busy            - run in progress (RST0 .. CAPTURE)
//            done            - one-cycle pulse, coordinates valid
//            mem_addr        - pixel-memory read address
//            mem_rdata       - pixel byte, 1-cycle read latency
//            wr_en / rd_en   - simpleBox write / read strobes
//            hex_value_index - {byte value, byte index} to simpleBox
//            box_out         - simpleBox result {x_min,y_min,x_max,y_max}
//            x_min..y_max    - captured coordinates, held until next capture
// Revision : 1.0 - initial release
// ============================================================================
module simplebox_streamer #(
  parameter int WIDTH     = simplebox_pkg::WIDTH,
  parameter int HEIGHT    = simplebox_pkg::HEIGHT,
  parameter int RESET_IDX = simplebox_pkg::RESET_IDX,
  parameter int ADDR_W    = 24
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              wr_en,
  output logic              rd_en,
  output logic [31:0]       hex_value_index,
  input  logic [31:0]       box_out,
  output logic [7:0]        x_min,
  output logic [7:0]        y_min,
  output logic [7:0]        x_max,
  output logic [7:0]        y_max
);

  import simplebox_pkg::*;

  localparam int                C_N    = WIDTH * HEIGHT * 3;
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(C_N - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [IDX_W-1:0]  r_idx;
  logic [VAL_W-1:0]  r_val;
  logic              r_busy;
  logic              r_done;
  logic              r_wr_en;
  logic              r_rd_en;
  logic [31:0]       r_coord;
  logic [31:0]       w_box;

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (start) w_next = RST0;
      RST0:     w_next = RST1;
      RST1:     w_next = PREFETCH;
      PREFETCH: w_next = STREAM;
      STREAM:   if (r_cnt == C_LAST) w_next = DRAIN;
      DRAIN:    w_next = READ;
      READ:     w_next = CAPTURE;
      CAPTURE:  w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Counter value for the next STREAM cycle: 0 when entering from PREFETCH
  assign w_cnt_nxt = (r_state == STREAM) ? (r_cnt + ADDR_W'(1)) : '0;

  // State and registered outputs; outputs are computed from the next state so
  // they line up with the state they belong to.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_idx   <= '0;
      r_val   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_coord <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      r_done  <= (w_next == CAPTURE);
      r_wr_en <= (w_next == STREAM);
      r_rd_en <= (w_next == READ);

      // Keep the last streamed byte so the value field holds through DRAIN
      if (r_state == STREAM) r_val <= mem_rdata;

      // Result is live on box_out during the done cycle; keep it afterwards
      if (r_done) r_coord <= box_out;

      case (w_next)
        RST0: begin
          r_idx <= IDX_W'(RESET_IDX);
          r_val <= '0;
          r_cnt <= '0;
        end
        RST1:     r_idx  <= IDX_W'(RESET_IDX + 1);
        PREFETCH: r_addr <= '0;
        STREAM: begin
          r_cnt  <= w_cnt_nxt;
          r_idx  <= IDX_W'(w_cnt_nxt);
          // Prefetch the next byte; park on the last address at the end
          r_addr <= (w_cnt_nxt == C_LAST) ? C_LAST : (w_cnt_nxt + ADDR_W'(1));
        end
        default: ;
      endcase
    end
  end

  // The memory already registers its output, so the byte for index i is on
  // mem_rdata during STREAM cycle i and is forwarded directly.
  assign hex_value_index[IDX_MSB:IDX_LSB] = r_idx;
  assign hex_value_index[VAL_MSB:VAL_LSB] = r_wr_en ? mem_rdata : r_val;

  // simpleBox presents its result the cycle after rd_en (the done cycle);
  // forward it then so the coordinates are visible together with done.
  assign w_box = r_done ? box_out : r_coord;

  assign x_min    = w_box[XMIN_LSB +: COORD_W];
  assign y_min    = w_box[YMIN_LSB +: COORD_W];
  assign x_max    = w_box[XMAX_LSB +: COORD_W];
  assign y_max    = w_box[YMAX_LSB +: COORD_W];
  assign busy     = r_busy;
  assign done     = r_done;
  assign wr_en    = r_wr_en;
  assign rd_en    = r_rd_en;
  assign mem_addr = r_addr;

endmodule : simplebox_streamer
`default_nettype wire

// File: tb/tb_simplebox_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_simplebox_streamer
// Purpose  : Directed self-checking bench for simplebox_streamer using a small
//            4x2 image, a behavioural sync-read pixel RAM and a simpleBox
//            stub that returns a programmed result the cycle after rd_en.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_simplebox_streamer;

  localparam int W      = 4;
  localparam int H      = 2;
  localparam int N      = W * H * 3;
  localparam int RIDX   = 99999;
  localparam int BOUND  = N + 50;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n  = 1'b0;
  logic        start    = 1'b0;
  logic        busy;
  logic        done;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] hex_value_index;
  logic [31:0] box_out = 32'h0;
  logic [7:0]  x_min, y_min, x_max, y_max;

  logic [7:0]  mem  [0:N-1];
  logic [7:0]  memA [0:N-1];
  logic [7:0]  memB [0:N-1];
  logic [31:0] stub_val = 32'h0;

  int checks   = 0;
  int errors   = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;
  int exp_idx  = 0;
  int lat;

  simplebox_streamer #(
    .WIDTH(W), .HEIGHT(H), .RESET_IDX(RIDX), .ADDR_W(24)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .busy(busy),
    .done(done), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .wr_en(wr_en),
    .rd_en(rd_en), .hex_value_index(hex_value_index), .box_out(box_out),
    .x_min(x_min), .y_min(y_min), .x_max(x_max), .y_max(y_max)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Pixel RAM, one-cycle read latency
  always @(posedge CLOCK_50) mem_rdata <= mem[mem_addr];

  // simpleBox stub: result valid only in the cycle after rd_en
  always @(posedge CLOCK_50) box_out <= rd_en ? stub_val : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: every write carries the next index and its byte
  always @(negedge CLOCK_50) begin
    if (wr_en === 1'b1) begin
      chk("wr_idx", {8'h0, hex_value_index[23:0]}, exp_idx);
      chk("wr_val", {24'h0, hex_value_index[31:24]}, {24'h0, mem[exp_idx]});
      exp_idx++;
      wr_cnt++;
    end
    if (rd_en === 1'b1) rd_cnt++;
    if (done === 1'b1) done_cnt++;
    if (wr_en === 1'b1 && rd_en === 1'b1) chk("wr_rd_overlap", 32'd1, 32'd0);
  end

  task automatic clr_counts();
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; exp_idx = 0;
  endtask

  task automatic chk_coords(input string tag, input logic [31:0] exp);
    chk(tag, {x_min, y_min, x_max, y_max}, exp);
  endtask

  // Called at a negedge. Returns in the done cycle (or on bound expiry) with
  // lat = cycles from the RST0 cycle to the done cycle.
  task automatic do_run(input bit detail, input int pulse_at, output int l);
    start = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    start = 1'b0;
    l = 0;
    if (detail) begin
      chk("rst0_idx", {8'h0, hex_value_index[23:0]}, RIDX);
      chk("rst0_wr", wr_en, 0);
      chk("rst0_busy", busy, 1);
      @(negedge CLOCK_50); l++;
      chk("rst1_idx", {8'h0, hex_value_index[23:0]}, RIDX + 1);
      chk("rst1_wr", wr_en, 0);
      @(negedge CLOCK_50); l++;
      chk("pref_addr", mem_addr, 0);
      chk("pref_wr", wr_en, 0);
      @(negedge CLOCK_50); l++;
      chk("first_wr", wr_en, 1);
      chk("first_addr", mem_addr, 1);
    end
    while (done !== 1'b1 && l < BOUND) begin
      @(negedge CLOCK_50);
      l++;
      start = (l == pulse_at);
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      memA[i] = 8'((i * 13 + 5) & 255);
      memB[i] = 8'((255 - i * 7) & 255);
      mem[i]  = memA[i];
    end

    // Reset and idle behaviour
    repeat (3) @(negedge CLOCK_50);
    reset_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr", wr_en, 0);
    chk("rst_rd", rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_hvi", hex_value_index, 0);
    chk_coords("rst_coords", 32'h0);
    repeat (100) @(negedge CLOCK_50);
    #1;
    chk("idle_wr_cnt", wr_cnt, 0);
    chk("idle_rd_cnt", rd_cnt, 0);
    chk("idle_done_cnt", done_cnt, 0);
    chk("idle_busy", busy, 0);
    chk_coords("idle_coords", 32'h0);

    // Run A: image A, start also pulsed in the done cycle
    clr_counts();
    stub_val = 32'h1C22454E;
    do_run(1'b0, -1, lat);
    chk("A_latency", lat, N + 5);
    chk_coords("A_coords_done", 32'h1C22454E);
    chk("A_wr_cnt", wr_cnt, N);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    chk("A_busy_after", busy, 0);
    chk_coords("A_coords_held", 32'h1C22454E);
    chk("A_last_addr", mem_addr, N - 1);
    @(negedge CLOCK_50);
    #1;
    chk("A_start_in_done_ignored", busy, 0);
    chk("A_done_cnt", done_cnt, 1);
    chk("A_rd_cnt", rd_cnt, 1);

    // Run B: image B, restart sequence checked cycle by cycle
    for (int i = 0; i < N; i++) mem[i] = memB[i];
    clr_counts();
    stub_val = 32'h0410544D;
    do_run(1'b1, -1, lat);
    chk("B_latency", lat, N + 5);
    chk_coords("B_coords", 32'h0410544D);

    // Run C: back-to-back start in first IDLE cycle, start pulsed mid-stream
    @(negedge CLOCK_50);
    #1;
    chk("B_done_cnt", done_cnt, 1);
    chk("B_wr_cnt", wr_cnt, N);
    chk_coords("B_coords_held", 32'h0410544D);
    clr_counts();
    stub_val = 32'hDEADBEEF;
    do_run(1'b0, 10, lat);
    chk("C_latency", lat, N + 5);
    chk_coords("C_coords", 32'hDEADBEEF);
    repeat (3) @(negedge CLOCK_50);
    #1;
    chk("C_wr_cnt", wr_cnt, N);
    chk("C_done_cnt", done_cnt, 1);
    chk("C_busy_idle", busy, 0);

    // Mid-run reset at byte N/2, then a fresh run on image A
    for (int i = 0; i < N; i++) mem[i] = memA[i];
    clr_counts();
    stub_val = 32'h1C22454E;
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    for (int g = 0; g < BOUND && exp_idx < N / 2; g++) @(negedge CLOCK_50);
    chk("R_reached_half", exp_idx, N / 2);
    reset_n = 1'b0;
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    chk("R_wr", wr_en, 0);
    chk("R_rd", rd_en, 0);
    chk("R_busy", busy, 0);
    chk("R_addr", mem_addr, 0);
    chk("R_hvi", hex_value_index, 0);
    chk_coords("R_coords_cleared", 32'h0);
    @(negedge CLOCK_50);
    chk("R_stays_idle", busy, 0);
    clr_counts();
    do_run(1'b0, -1, lat);
    chk("R2_latency", lat, N + 5);
    chk_coords("R2_coords", 32'h1C22454E);
    @(negedge CLOCK_50);
    #1;
    chk("R2_wr_cnt", wr_cnt, N);
    chk("R2_done_cnt", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_simplebox_streamer
`default_nettype wire
